clk_div_multi: RTL and testbench

//  Multi-channel programmable clock divider. Successor to the fixed single-divisor

---
 rtl/clk_div_multi.sv | 122 ++++++++++++
 tb/tb_clk_div_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider.
// Each channel divides clk_in by a runtime divisor D and stays high for H
// cycles of every period. New settings are staged in a shadow register and
// only become active at a period boundary, or at once while the channel is
// disabled, so clk_out never glitches mid-period.
module clk_div_multi #(
    parameter int CH       = 3,
    parameter int CNT_W    = 28,
    parameter int DEF_DIV  = 100000000,
    parameter int DEF_HIGH = 50000000,
    localparam int CH_W    = $clog2(CH)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH_V = CNT_W'(DEF_HIGH);

    logic ch_ok;
    logic div_ok;
    logic high_ok;
    logic cfg_valid;
    logic wr_ok;

    // Validate a config write in the cycle it is presented.
    // The channel compare is widened so it stays meaningful when CH is a power of two.
    always_comb begin
        ch_ok     = (32'(cfg_ch) < 32'(CH));
        div_ok    = (cfg_div >= CNT_W'(2));
        high_ok   = (cfg_high <= cfg_div);
        cfg_valid = ch_ok && div_ok && high_ok;
        wr_ok     = cfg_we && cfg_valid;
    end

    // Report the outcome of a write one cycle later; valid and invalid are exclusive.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= wr_ok;
            cfg_err <= cfg_we && !cfg_valid;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] act_high;
        logic [CNT_W-1:0] sh_div;
        logic [CNT_W-1:0] sh_high;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             wrap;
        logic             sel;

        // Decode the period wrap and whether this channel is the target of a valid write.
        always_comb begin
            wrap = (cnt == (act_div - CNT_W'(1)));
            sel  = wr_ok && (cfg_ch == CH_W'(i));
        end

        // Per-channel counter with shadowed config; a write landing on the wrap
        // edge is only staged, since the wrap itself sees the old pend/shadow.
        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt      <= '0;
                act_div  <= DEF_DIV_V;
                act_high <= DEF_HIGH_V;
                sh_div   <= DEF_DIV_V;
                sh_high  <= DEF_HIGH_V;
                pend     <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (en[i]) begin
                    clk_q  <= (cnt < act_high);
                    tick_q <= wrap;
                    if (wrap) begin
                        cnt <= '0;
                        if (pend) begin
                            act_div  <= sh_div;
                            act_high <= sh_high;
                            pend     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        act_div  <= sh_div;
                        act_high <= sh_high;
                        pend     <= 1'b0;
                    end
                end
                if (sel) begin
                    sh_div  <= cfg_div;
                    sh_high <= cfg_high;
                    pend    <= 1'b1;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed bench for clk_div_multi (CH=3, CNT_W=8, 10/5 defaults).
// Expected waveforms come from hand-chosen D/H/phase values per channel that
// the bench switches at the period boundaries worked out for each scenario.
module tb_clk_div_multi;

    localparam int CH    = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk_in = 1'b0;
    logic             rst;
    logic [CH-1:0]    en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_ack;
    logic             cfg_err;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;

    int checks = 0;
    int errors = 0;

    int wd [CH];
    int wh [CH];
    int wph[CH];
    bit won[CH];
    bit exp_ack;
    bit exp_err;

    clk_div_multi #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (10),
        .DEF_HIGH(5)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_high(cfg_high),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Samples n cycles on the falling edge and compares cfg pulses and all channel outputs.
    task automatic checkCycles(input int n);
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_tick;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            checkOutput("cfg", {30'd0, cfg_ack, cfg_err}, {30'd0, exp_ack, exp_err});
            exp_ack = 1'b0;
            exp_err = 1'b0;
            cfg_we  = 1'b0;
            for (int c = 0; c < CH; c++) begin
                exp_tick[c] = won[c] && (wph[c] == wd[c] - 1);
                exp_clk[c]  = won[c] && (wph[c] < wh[c]);
                if (won[c])
                    wph[c] = (wph[c] == wd[c] - 1) ? 0 : wph[c] + 1;
            end
            checkOutput("wave", {26'd0, tick, clk_out}, {26'd0, exp_tick, exp_clk});
        end
    endtask

    task automatic applyStimulus(input int ch, input int d, input int h, input bit ok);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(d);
        cfg_high = CNT_W'(h);
        exp_ack  = ok;
        exp_err  = !ok;
    endtask

    task automatic setEnable(input logic [CH-1:0] e);
        for (int c = 0; c < CH; c++) begin
            if (e[c] && !won[c])
                wph[c] = 0;
            won[c] = e[c];
        end
        en = e;
    endtask

    // Runs until the next sample of channel ch will show phase ph.
    task automatic runToPhase(input int ch, input int ph);
        checkCycles((ph - wph[ch] + wd[ch]) % wd[ch]);
    endtask

    initial begin
        rst      = 1'b1;
        en       = '0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            wd[c]  = 10;
            wh[c]  = 5;
            wph[c] = 0;
            won[c] = 1'b0;
        end

        // Reset for two cycles: everything low.
        checkCycles(2);
        rst = 1'b0;

        // Default 5 high / 5 low on channel 0 only.
        $display("[TB] default waveform on ch0");
        setEnable(3'b001);
        checkCycles(30);

        // Write D=4 H=1 at cnt=3; the running period finishes unchanged.
        $display("[TB] staged write on ch0");
        runToPhase(0, 3);
        applyStimulus(0, 4, 1, 1'b1);
        checkCycles(1);
        runToPhase(0, 0);
        wd[0] = 4;
        wh[0] = 1;
        checkCycles(12);

        // Rejected writes leave every waveform alone.
        $display("[TB] rejected writes");
        applyStimulus(0, 1, 0, 1'b0);
        checkCycles(1);
        applyStimulus(0, 10, 11, 1'b0);
        checkCycles(1);
        applyStimulus(3, 4, 1, 1'b0);
        checkCycles(1);
        checkCycles(8);

        // H=0 and H=D extremes, applied while disabled.
        $display("[TB] constant-low and constant-high channels");
        applyStimulus(1, 10, 0, 1'b1);
        checkCycles(1);
        applyStimulus(2, 6, 6, 1'b1);
        checkCycles(1);
        checkCycles(1);
        wd[1] = 10; wh[1] = 0;
        wd[2] = 6;  wh[2] = 6;
        setEnable(3'b111);
        checkCycles(12);

        // Back-to-back writes to running ch1: the last one wins at the wrap.
        applyStimulus(1, 9, 0, 1'b1);
        checkCycles(1);
        applyStimulus(1, 6, 0, 1'b1);
        checkCycles(1);
        runToPhase(1, 0);
        wd[1] = 6;
        checkCycles(18);

        // Write on ch2's wrap cycle waits for the following wrap.
        $display("[TB] write on wrap cycle");
        runToPhase(2, 5);
        applyStimulus(2, 4, 2, 1'b1);
        checkCycles(1);
        checkCycles(6);
        wd[2] = 4;
        wh[2] = 2;
        checkCycles(8);

        // Disable with a pending write: new settings apply on re-enable.
        $display("[TB] disable applies pending config");
        runToPhase(0, 1);
        applyStimulus(0, 6, 3, 1'b1);
        checkCycles(1);
        setEnable(3'b110);
        checkCycles(1);
        wd[0] = 6;
        wh[0] = 3;
        setEnable(3'b111);
        checkCycles(12);

        // Configure all channels, then reset mid-period.
        $display("[TB] reset mid-operation");
        setEnable(3'b000);
        checkCycles(1);
        applyStimulus(0, 5, 2, 1'b1);
        checkCycles(1);
        applyStimulus(1, 3, 1, 1'b1);
        checkCycles(1);
        applyStimulus(2, 7, 7, 1'b1);
        checkCycles(1);
        checkCycles(1);
        wd[0] = 5; wh[0] = 2;
        wd[1] = 3; wh[1] = 1;
        wd[2] = 7; wh[2] = 7;
        setEnable(3'b111);
        checkCycles(4);
        applyStimulus(0, 8, 4, 1'b1);
        checkCycles(1);
        rst = 1'b1;
        for (int c = 0; c < CH; c++)
            won[c] = 1'b0;
        checkCycles(2);
        rst = 1'b0;
        for (int c = 0; c < CH; c++) begin
            won[c] = 1'b1;
            wph[c] = 0;
            wd[c]  = 10;
            wh[c]  = 5;
        end
        checkCycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
